// File: rtl/uart_tx_serializer_pkg.sv
// Shared UART definitions: serializer state encoding, parity codes and frame lengths.
package uart_tx_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NONE_0 = 2'b00,
        ODD    = 2'b01,
        EVEN   = 2'b10,
        NONE_3 = 2'b11
    } parity_t;

    localparam int LEN_PARITY   = 11;
    localparam int LEN_NOPARITY = 10;

    // Data plus stop bits always total 9, so only parity changes the frame length.
    function automatic logic [3:0] frame_len(input logic [1:0] ptype);
        if (ptype == ODD || ptype == EVEN)
            return 4'(LEN_PARITY);
        return 4'(LEN_NOPARITY);
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: shifts an assembled frame LSB-first, one bit per baud tick.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int FRAME_W = 11,
    parameter int CNT_W   = 4
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [FRAME_W-1:0] FrameIn,
    input  logic [1:0]         ParityType,
    input  logic               StopBits,
    input  logic               DataLength,
    input  logic               Send,
    input  logic               BaudTick,
    output logic               DataOut,
    output logic               Active,
    output logic               Done
);

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   len, len_n;
    logic               tx, tx_n;
    logic               active, active_n;
    logic               done, done_n;

    // Stop/data-length codes are already encoded in FrameIn and never alter the length.
    logic unused_cfg;
    assign unused_cfg = ^{StopBits, DataLength};

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state  <= IDLE;
            shreg  <= '1;
            cnt    <= '0;
            len    <= '0;
            tx     <= 1'b1;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            len    <= len_n;
            tx     <= tx_n;
            active <= active_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        len_n    = len;
        tx_n     = tx;
        active_n = active;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (Send) begin
                    shreg_n  = FrameIn;
                    len_n    = CNT_W'(frame_len(ParityType));
                    cnt_n    = '0;
                    active_n = 1'b1;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                // The extra tick after the last bit lets that bit hold a full period.
                if (BaudTick) begin
                    if (cnt < len) begin
                        tx_n    = shreg[0];
                        shreg_n = {1'b1, shreg[FRAME_W-1:1]};
                        cnt_n   = cnt + CNT_W'(1);
                    end else begin
                        tx_n     = 1'b1;
                        active_n = 1'b0;
                        done_n   = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign DataOut = tx;
    assign Active  = active;
    assign Done    = done;

endmodule
